seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's BCD-to-7-segment driver.
- Samples a multiplexed 7-segment display bus (segment pattern plus active-low digit select), filters glitches and decodes each digit pattern back to a 4-bit code.
- Assembles NUM_DIG digits into a frame and presents the frame to downstream logic (self-check, display readback) through a valid/ready handshake.

---
 rtl/seg_scan_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//   Receive-side decoder for a multiplexed 7-segment display bus. The bus is
//   sampled every clock, each digit pattern must be stable for STABLE_CYC
//   samples before it is accepted, accepted patterns are decoded back to a
//   4-bit code, and NUM_DIG digits (scanned in order 0..NUM_DIG-1) are
//   assembled into a frame that is handed downstream over valid/ready.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   seg        segment pattern {a,b,c,d,e,f,g}, 1 = lit
//   sel_n      active-low one-hot digit select, all-ones = blanking
//   digits     decoded frame, digit i in bits [4i+3:4i]
//   dig_err    per-digit decode error flags for the presented frame
//   out_valid  frame available
//   out_ready  consumer accepts the frame
//   seq_err    one-cycle pulse on a digit-order violation
//   overrun    sticky: a completed frame was dropped under backpressure
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             seg,
  input  logic [NUM_DIG-1:0]     sel_n,
  output logic [4*NUM_DIG-1:0]   digits,
  output logic [NUM_DIG-1:0]     dig_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   seq_err,
  output logic                   overrun
);

  localparam int              IW     = $clog2(NUM_DIG);
  localparam logic [IW-1:0]   LAST   = IW'(NUM_DIG - 1);
  localparam logic [7:0]      STABLE = 8'(STABLE_CYC);

  typedef enum logic [1:0] {WAIT0, COLLECT, COMPLETE} state_t;

  // True when exactly one select line is low (a real digit, not blanking or
  // an overlap between two digits).
  function automatic logic one_low(input logic [NUM_DIG-1:0] s);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!s[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [IW-1:0] low_idx(input logic [NUM_DIG-1:0] s);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!s[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Sample register and stability filter
  // ---------------------------------------------------------------------------
  logic [6:0]         samp_seg;
  logic [NUM_DIG-1:0] samp_sel;
  logic [7:0]         cnt;
  logic [7:0]         cnt_next;
  logic               same;
  logic               acc;
  logic               acc_next;

  assign same     = (seg == samp_seg) && (sel_n == samp_sel);
  assign cnt_next = !same ? 8'd1 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  // Fire only on the transition into STABLE; the "!same" term lets a fresh
  // pattern fire even when the previous one also sat at STABLE (STABLE_CYC=1),
  // while a saturated count held at STABLE never re-fires.
  assign acc_next = one_low(sel_n) && (cnt_next == STABLE) && (!same || cnt != STABLE);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_seg <= '0;
      samp_sel <= '1;
      cnt      <= '0;
      acc      <= 1'b0;
    end else begin
      samp_seg <= seg;
      samp_sel <= sel_n;
      cnt      <= cnt_next;
      acc      <= acc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern decode of the accepted sample
  // ---------------------------------------------------------------------------
  logic [3:0]    dec_code;
  logic          dec_err;
  logic [IW-1:0] acc_idx;

  assign acc_idx = low_idx(samp_sel);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_code = 4'hF;
    dec_err  = 1'b0;
    unique case (samp_seg)
      7'b1111110: dec_code = 4'd0;
      7'b0110000: dec_code = 4'd1;
      7'b1101101: dec_code = 4'd2;
      7'b1111001: dec_code = 4'd3;
      7'b0110011: dec_code = 4'd4;
      7'b1011011: dec_code = 4'd5;
      7'b1011111: dec_code = 4'd6;
      7'b1110000: dec_code = 4'd7;
      7'b1111111: dec_code = 4'd8;
      7'b1111011: dec_code = 4'd9;
      7'b1001111: begin dec_code = 4'hE; dec_err = 1'b1; end
      default:    begin dec_code = 4'hF; dec_err = 1'b1; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame assembly FSM
  // ---------------------------------------------------------------------------
  state_t        state, state_n;
  logic [IW-1:0] exp_idx, exp_n;
  logic          store;
  logic          viol;

  always_comb begin
    state_n = state;
    exp_n   = exp_idx;
    store   = 1'b0;
    viol    = 1'b0;
    unique case (state)
      WAIT0: begin
        if (acc && acc_idx == '0) begin
          store   = 1'b1;
          exp_n   = IW'(1);
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (acc) begin
          if (acc_idx == exp_idx) begin
            store = 1'b1;
            if (acc_idx == LAST) state_n = COMPLETE;
            else                 exp_n   = exp_idx + IW'(1);
          end else if (acc_idx == '0) begin
            // Scan restarted early: keep the new digit 0 as a fresh frame.
            viol  = 1'b1;
            store = 1'b1;
            exp_n = IW'(1);
          end else begin
            viol    = 1'b1;
            state_n = WAIT0;
          end
        end
      end
      COMPLETE: state_n = WAIT0;
      default:  state_n = WAIT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT0;
      exp_idx <= '0;
    end else begin
      state   <= state_n;
      exp_idx <= exp_n;
    end
  end

  // NOTE: the frame buffer has no reset; every slot is rewritten before the
  // FSM can reach COMPLETE, so stale contents are never delivered.
  logic [4*NUM_DIG-1:0] frm;
  logic [NUM_DIG-1:0]   frm_err;

  always_ff @(posedge clk) begin
    if (store) begin
      frm[4*acc_idx +: 4] <= dec_code;
      frm_err[acc_idx]    <= dec_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake
  // ---------------------------------------------------------------------------
  logic deliver;
  assign deliver = (state == COMPLETE);

  always_ff @(posedge clk) begin
    if (rst) begin
      digits    <= '0;
      dig_err   <= '0;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Back-to-back violations cannot stretch the pulse past one cycle.
      seq_err <= viol && !seq_err;
      if (deliver) begin
        if (!out_valid || out_ready) begin
          digits    <= frm;
          dig_err   <= frm_err;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//   Directed bench for seg_scan_decoder (NUM_DIG=4, STABLE_CYC=4). A
//   transaction-level model predicts every output each cycle; literal checks
//   pin the decoded frames, timing and flags of each scenario.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] sel_n;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dig_err;
  logic          out_valid;
  logic          out_ready;
  logic          seq_err;
  logic          overrun;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIG(ND), .STABLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .seg(seg), .sel_n(sel_n),
    .digits(digits), .dig_err(dig_err), .out_valid(out_valid),
    .out_ready(out_ready), .seq_err(seq_err), .overrun(overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [6:0] pat_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  task automatic decode(input logic [6:0] p, output logic [3:0] c, output bit e);
    c = 4'hF;
    e = 1'b1;
    if (p == 7'b1001111) c = 4'hE;
    for (int i = 0; i < 10; i++) begin
      if (pat_tbl[i] == p) begin
        c = 4'(i);
        e = 1'b0;
      end
    end
  endtask

  function automatic int low_count(input logic [ND-1:0] s);
    int n = 0;
    for (int i = 0; i < ND; i++) if (!s[i]) n++;
    return n;
  endfunction

  function automatic int low_pos(input logic [ND-1:0] s);
    int p = 0;
    for (int i = 0; i < ND; i++) if (!s[i]) p = i;
    return p;
  endfunction

  // Input history: the last value seen and how many edges in a row it lasted.
  logic [6:0]    m_last_seg;
  logic [ND-1:0] m_last_sel;
  int            m_run;
  // Digit accepted at the previous edge, handled by frame assembly now.
  bit            m_acc_v;
  int            m_acc_idx;
  logic [3:0]    m_acc_code;
  bit            m_acc_err;
  // Frame assembly: -1 = waiting for digit 0, else next expected digit.
  int            m_pos;
  logic [3:0]    m_frame [ND];
  bit            m_ferr  [ND];
  // Frame completed at the previous edge, handed to the output now.
  bit              m_dlv_v;
  logic [4*ND-1:0] m_dlv_d;
  logic [ND-1:0]   m_dlv_e;
  // Predicted outputs.
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_derr;
  bit              m_valid, m_seq, m_ovr;
  bit              live = 1'b0;

  task automatic model_step(input bit r, input logic [6:0] s, input logic [ND-1:0] n, input bit rdy);
    bit viol, new_dlv;
    if (r) begin
      m_last_seg = '0; m_last_sel = '1; m_run = 0;
      m_acc_v = 0; m_pos = -1; m_dlv_v = 0;
      m_digits = '0; m_derr = '0; m_valid = 0; m_seq = 0; m_ovr = 0;
      return;
    end
    // Output side
    if (m_dlv_v) begin
      if (!m_valid || rdy) begin
        m_digits = m_dlv_d; m_derr = m_dlv_e; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    // Frame assembly (ignores digits during the delivery cycle)
    viol = 0; new_dlv = 0;
    if (m_acc_v && !m_dlv_v) begin
      if (m_pos < 0) begin
        if (m_acc_idx == 0) begin
          m_frame[0] = m_acc_code; m_ferr[0] = m_acc_err; m_pos = 1;
        end
      end else if (m_acc_idx == m_pos) begin
        m_frame[m_acc_idx] = m_acc_code; m_ferr[m_acc_idx] = m_acc_err;
        if (m_acc_idx == ND - 1) begin
          new_dlv = 1; m_pos = -1;
          for (int i = 0; i < ND; i++) begin
            m_dlv_d[4*i +: 4] = m_frame[i];
            m_dlv_e[i]        = m_ferr[i];
          end
        end else begin
          m_pos++;
        end
      end else if (m_acc_idx == 0) begin
        viol = 1;
        m_frame[0] = m_acc_code; m_ferr[0] = m_acc_err; m_pos = 1;
      end else begin
        viol = 1; m_pos = -1;
      end
    end
    m_seq   = viol && !m_seq;
    m_dlv_v = new_dlv;
    // Stability: accept on exactly the SC-th identical consecutive sample.
    if (s == m_last_seg && n == m_last_sel) m_run++;
    else                                    m_run = 1;
    m_last_seg = s; m_last_sel = n;
    m_acc_v   = (m_run == SC) && (low_count(n) == 1);
    m_acc_idx = low_pos(n);
    decode(s, m_acc_code, m_acc_err);
  endtask

  // Per-cycle compare against the model, plus observation counters.
  int  rises = 0, seq_cnt = 0, seq_run = 0, seq_max = 0;
  bit  pv = 1'b0;

  always @(negedge clk) begin
    if (live) begin
      check("digits",    32'(digits),    32'(m_digits));
      check("dig_err",   32'(dig_err),   32'(m_derr));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("seq_err",   32'(seq_err),   32'(m_seq));
      check("overrun",   32'(overrun),   32'(m_ovr));
      if (out_valid && !pv) rises++;
      pv = out_valid;
      if (seq_err) begin
        seq_cnt++; seq_run++;
        if (seq_run > seq_max) seq_max = seq_run;
      end else begin
        seq_run = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  localparam logic [6:0] BLANK = 7'b0000000;

  function automatic logic [ND-1:0] sel_of(input int i);
    logic [ND-1:0] v;
    v = '1;
    v[i] = 1'b0;
    return v;
  endfunction

  task automatic step(input logic [6:0] s, input logic [ND-1:0] n);
    seg = s; sel_n = n;
    @(posedge clk);
    model_step(rst, s, n, out_ready);
    live = 1'b1;
    #1;
  endtask

  task automatic dig(input int i, input logic [6:0] p, input int hold, input int gap);
    repeat (hold) step(p, sel_of(i));
    repeat (gap)  step(BLANK, '1);
  endtask

  task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    dig(0, p0, 6, 2); dig(1, p1, 6, 2); dig(2, p2, 6, 2); dig(3, p3, 6, 2);
  endtask

  int r0, s0;

  initial begin
    rst = 1'b1; out_ready = 1'b1; seg = BLANK; sel_n = '1;
    step(BLANK, '1);
    step(BLANK, '1);
    check("rst_digits",  32'(digits),    32'h0);
    check("rst_dig_err", 32'(dig_err),   32'h0);
    check("rst_valid",   32'(out_valid), 32'h0);
    check("rst_seq",     32'(seq_err),   32'h0);
    check("rst_overrun", 32'(overrun),   32'h0);
    rst = 1'b0;
    step(BLANK, '1);

    // Clean frame with latency probe on the last digit.
    dig(0, 7'b1111001, 6, 2);
    dig(1, 7'b0110000, 6, 2);
    dig(2, 7'b1111011, 6, 2);
    for (int k = 1; k <= 6; k++) begin
      step(7'b1111110, sel_of(3));
      check("clean_valid_timing", 32'(out_valid), 32'(k == SC + 2));
    end
    check("clean_digits",  32'(digits),  32'h0913);
    check("clean_dig_err", 32'(dig_err), 32'h0);
    step(BLANK, '1);
    check("clean_valid_one_cycle", 32'(out_valid), 32'h0);
    step(BLANK, '1);
    check("clean_rises", 32'(rises), 32'd1);

    // Glitch rejection: 3-cycle pattern ignored, then a long hold stores once.
    dig(0, 7'b1111110, 6, 2);
    dig(1, 7'b0110000, 3, 0);
    dig(1, 7'b1110000, 20, 2);
    dig(2, 7'b1111001, 6, 2);
    dig(3, 7'b1011011, 6, 2);
    check("glitch_digits", 32'(digits),  32'h5370);
    check("glitch_seq",    32'(seq_cnt), 32'd0);
    check("glitch_rises",  32'(rises),   32'd2);

    // Error decode.
    frame(7'b1111110, 7'b0110000, 7'b1001111, 7'b0000000);
    check("err_digits",  32'(digits),  32'hFE10);
    check("err_dig_err", 32'(dig_err), 32'b1100);

    // Sequence violation 0,1,3 then a clean scan.
    r0 = rises;
    dig(0, 7'b1111110, 6, 2);
    dig(1, 7'b0110000, 6, 2);
    dig(3, 7'b1111110, 6, 2);
    check("seq_pulses",   32'(seq_cnt), 32'd1);
    check("seq_width",    32'(seq_max), 32'd1);
    check("seq_no_frame", 32'(rises),   32'(r0));
    frame(7'b0110011, 7'b1011111, 7'b1111111, 7'b1110000);
    check("seq_recover", 32'(digits), 32'h7864);

    // Backpressure: hold frame A, drop frame B, load C on the ready edge.
    out_ready = 1'b0;
    frame(7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);
    check("bp_a_digits",  32'(digits),    32'h4321);
    check("bp_a_valid",   32'(out_valid), 32'h1);
    check("bp_a_overrun", 32'(overrun),   32'h0);
    frame(7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111);
    check("bp_b_overrun", 32'(overrun),   32'h1);
    check("bp_b_held",    32'(digits),    32'h4321);
    dig(0, 7'b1111011, 6, 2);
    dig(1, 7'b1111110, 6, 2);
    dig(2, 7'b0110000, 6, 2);
    for (int k = 1; k <= 6; k++) begin
      step(7'b1101101, sel_of(3));
      if (k == SC + 1) out_ready = 1'b1;
    end
    check("bp_c_digits", 32'(digits),    32'h2109);
    check("bp_c_valid",  32'(out_valid), 32'h1);
    step(BLANK, '1);
    check("bp_c_cleared", 32'(out_valid), 32'h0);
    check("bp_sticky",    32'(overrun),   32'h1);
    step(BLANK, '1);

    // Reset mid-frame.
    dig(0, 7'b1111110, 6, 2);
    dig(1, 7'b0110000, 6, 0);
    rst = 1'b1;
    step(BLANK, '1);
    rst = 1'b0;
    check("mid_rst_digits",  32'(digits),    32'h0);
    check("mid_rst_valid",   32'(out_valid), 32'h0);
    check("mid_rst_overrun", 32'(overrun),   32'h0);
    step(BLANK, '1);
    r0 = rises; s0 = seq_cnt;
    dig(2, 7'b1111110, 6, 2);
    dig(3, 7'b1011111, 6, 2);
    check("mid_rst_no_frame", 32'(rises),   32'(r0));
    check("mid_rst_no_seq",   32'(seq_cnt), 32'(s0));
    frame(7'b1011011, 7'b1111011, 7'b1111110, 7'b1011111);
    check("mid_rst_frame", 32'(digits), 32'h6095);
    check("mid_rst_rises", 32'(rises),  32'(r0 + 1));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
